// File: rtl/mem_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_write_arbiter_if
// Brief    : Requester handshakes and memory write port of mem_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_write_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 36
);
    localparam int AW = $clog2(DEPTH);

    logic                  req0_valid;
    logic                  req0_ready;
    logic [AW-1:0]         req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [AW-1:0]         req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;

    logic                  mem_wea;
    logic [AW-1:0]         mem_addra;
    logic [DATA_WIDTH-1:0] mem_dia;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  mem_wea, mem_addra, mem_dia
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output mem_wea, mem_addra, mem_dia
    );
endinterface
`default_nettype wire

// File: rtl/mem_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_write_arbiter
// Brief    : Clears a memory after reset/on request, then round-robin
//            arbitrates two write requesters onto its single write port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_write_arbiter #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH       = 36,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    input  wire logic         clear_req,
    output logic              busy,
    mem_write_arbiter_if.slave bus
);
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  mem_wea_q, mem_wea_d;
    logic [AW-1:0]         mem_addra_q, mem_addra_d;
    logic [DATA_WIDTH-1:0] mem_dia_q, mem_dia_d;
    logic                  ready0;
    logic                  ready1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            mem_wea_q    <= 1'b0;
            mem_addra_q  <= '0;
            mem_dia_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mem_wea_q    <= mem_wea_d;
            mem_addra_q  <= mem_addra_d;
            mem_dia_q    <= mem_dia_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        mem_wea_d    = 1'b0;
        mem_addra_d  = mem_addra_q;
        mem_dia_d    = mem_dia_q;
        ready0       = 1'b0;
        ready1       = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                mem_wea_d   = 1'b1;
                mem_addra_d = cnt_q;
                mem_dia_d   = CLEAR_VALUE;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_RUN: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else begin
                    // On a tie the requester not granted last time wins.
                    if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
                        ready0 = 1'b1;
                    end else if (bus.req1_valid) begin
                        ready1 = 1'b1;
                    end

                    if (ready0) begin
                        mem_wea_d    = 1'b1;
                        mem_addra_d  = bus.req0_addr;
                        mem_dia_d    = bus.req0_data;
                        last_grant_d = 1'b0;
                    end else if (ready1) begin
                        mem_wea_d    = 1'b1;
                        mem_addra_d  = bus.req1_addr;
                        mem_dia_d    = bus.req1_data;
                        last_grant_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy           = (state_q == S_CLEAR);
    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.mem_wea    = mem_wea_q;
    assign bus.mem_addra  = mem_addra_q;
    assign bus.mem_dia    = mem_dia_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_write_arbiter
// Brief    : Scoreboard bench for mem_write_arbiter (DEPTH=8, CLEAR_VALUE=5A).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_write_arbiter;
    localparam int             DW    = 8;
    localparam int             DEPTH = 8;
    localparam int             AW    = 3;
    localparam logic [DW-1:0]  CV    = 8'h5A;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n;
    logic clear_req;
    logic busy;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mem_write_arbiter_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    mem_write_arbiter #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .CLEAR_VALUE (CV)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .busy      (busy),
        .bus       (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int first, input int last);
        for (int a = first; a <= last; a++) push_wr(AW'(a), CV);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every memory write must match the next expected entry, in order.
    always @(negedge clk) begin
        if (bus.mem_wea === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", bus.mem_wea, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", bus.mem_addra, mon_e.addr);
                check("wr_data", bus.mem_dia, mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;

        reset_n        = 1'b0;
        clear_req      = 1'b0;
        a0 = 3'd2; d0 = 8'hAA;
        a1 = 3'd6; d1 = 8'hBB;
        bus.req0_valid = 1'b1; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = 1'b1; bus.req1_addr = a1; bus.req1_data = d1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  busy, 1'b1);
        check("rst_wea",   bus.mem_wea, 1'b0);
        check("rst_addra", bus.mem_addra, 0);
        check("rst_dia",   bus.mem_dia, 0);
        check("rst_rdy0",  bus.req0_ready, 1'b0);
        check("rst_rdy1",  bus.req1_ready, 1'b0);

        // Sweep after reset release, both requesters pending throughout.
        tick();
        reset_n = 1'b1;
        push_sweep(0, DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("sweep_busy", busy, 1'b1);
            check("sweep_rdy0", bus.req0_ready, 1'b0);
            check("sweep_rdy1", bus.req1_ready, 1'b0);
        end

        // Tie from reset state: grants must go 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) check("busy_fall", busy, 1'b0);
            check("alt_rdy0", bus.req0_ready, (k % 2) == 0);
            check("alt_rdy1", bus.req1_ready, (k % 2) == 1);
            if ((k % 2) == 0) push_wr(a0, d0);
            else              push_wr(a1, d1);
            tick();
            if ((k % 2) == 0) begin
                a0 = a0 + 3'd1; d0 = d0 + 8'd1;
                bus.req0_addr = a0; bus.req0_data = d0;
            end else begin
                a1 = a1 + 3'd1; d1 = d1 + 8'd1;
                bus.req1_addr = a1; bus.req1_data = d1;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("idle_wea",   bus.mem_wea, 1'b0);
        check("idle_addra", bus.mem_addra, 3'd7);
        check("idle_dia",   bus.mem_dia, 8'hBC);

        // Single requester 0, then single requester 1.
        tick();
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd3; bus.req0_data = 8'h11;
        @(negedge clk);
        check("r0_only_rdy0", bus.req0_ready, 1'b1);
        check("r0_only_rdy1", bus.req1_ready, 1'b0);
        push_wr(3'd3, 8'h11);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("r0_after_wea",   bus.mem_wea, 1'b0);
        check("r0_after_addra", bus.mem_addra, 3'd3);
        check("r0_after_dia",   bus.mem_dia, 8'h11);

        tick();
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd5; bus.req1_data = 8'h22;
        @(negedge clk);
        check("r1_only_rdy1", bus.req1_ready, 1'b1);
        check("r1_only_rdy0", bus.req0_ready, 1'b0);
        push_wr(3'd5, 8'h22);
        tick();
        bus.req1_valid = 1'b0;

        // clear_req together with req1; clear_req re-pulsed at sweep address 4.
        clear_req = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd4; bus.req1_data = 8'h33;
        @(negedge clk);
        check("clr_rdy1", bus.req1_ready, 1'b0);
        check("clr_rdy0", bus.req0_ready, 1'b0);
        push_sweep(0, DEPTH - 1);
        tick();
        clear_req = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            @(negedge clk);
            check("clr_sweep_busy", busy, 1'b1);
            check("clr_sweep_rdy1", bus.req1_ready, 1'b0);
            tick();
            clear_req = (j == 3);
        end
        @(negedge clk);
        check("clr_end_busy", busy, 1'b0);
        check("clr_end_rdy1", bus.req1_ready, 1'b1);
        push_wr(3'd4, 8'h33);
        tick();
        bus.req1_valid = 1'b0;

        // Reset pulse during sweep address 5 restarts the sweep from 0.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        push_sweep(0, 4);
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        push_sweep(0, DEPTH - 1);
        @(negedge clk);
        check("mid_rst_wea",  bus.mem_wea, 1'b0);
        check("mid_rst_busy", busy, 1'b1);
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            check("resweep_busy", busy, 1'b1);
        end
        @(negedge clk);
        check("resweep_done", busy, 1'b0);

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
